// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-bit datapath.
// Latency: strobes are combinational from state, op_q and handshakes; 2..5 cycles per instruction at zero wait.
// Backpressure: FETCH/MEM hold until imem_ack/dmem_ack; MEM gives up after MEM_TIMEOUT cycles. Option: PERF_CNT_EN.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       md_op,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_load,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       r15_write,
    output logic       branch,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0001;
    localparam logic [3:0] OP_RTYP = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic            md_q, md_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            berr_q, berr_d;

    function automatic logic is_load(input logic [3:0] op);
        return (op == 4'b1000) || (op == 4'b1010);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == 4'b1001) || (op == 4'b1011);
    endfunction

    function automatic logic is_logic_imm(input logic [3:0] op);
        return (op == 4'b1100) || (op == 4'b1101);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == 4'b0101) || (op == 4'b0100) || (op == 4'b0110);
    endfunction

    function automatic logic goes_to_exec(input logic [3:0] op);
        return (op == OP_RTYP) || is_logic_imm(op) || is_load(op) || is_store(op) || is_branch(op);
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic z, input logic n);
        logic taken;
        taken = 1'b0;
        case (op)
            4'b0101: taken = z;
            4'b0100: taken = n;
            4'b0110: taken = !z && !n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            md_q    <= 1'b0;
            timer_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            md_q    <= md_d;
            timer_q <= timer_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        md_d       = md_q;
        timer_d    = '0;
        berr_d     = berr_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_load    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        r15_write  = 1'b0;
        branch     = 1'b0;
        halted     = 1'b0;
        bus_err    = berr_q;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            // The opcode input is live here; op_q only carries it from EXEC onward.
            S_DECODE: begin
                op_d = opcode;
                md_d = md_op;
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_JMP) begin
                    pc_load = 1'b1;
                    state_d = S_FETCH;
                end else if (goes_to_exec(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXEC: begin
                if (op_q == OP_RTYP) begin
                    alu_op  = 2'b10;
                    state_d = S_WB;
                end else if (is_logic_imm(op_q)) begin
                    alu_op  = 2'b11;
                    alu_src = 1'b1;
                    state_d = S_WB;
                end else if (is_load(op_q) || is_store(op_q)) begin
                    alu_op  = 2'b00;
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else begin
                    alu_op  = 2'b01;
                    branch  = is_branch(op_q);
                    pc_load = branch_taken(op_q, flag_z, flag_n);
                    state_d = S_FETCH;
                end
            end

            // An ack arriving on the last allowed cycle still completes the transfer.
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = is_load(op_q);
                mem_write = is_store(op_q);
                if (dmem_ack) begin
                    state_d = is_load(op_q) ? S_WB : S_FETCH;
                end else if (timer_q == TIMER_LAST) begin
                    berr_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load(op_q);
                r15_write  = (op_q == OP_RTYP) && md_q;
                state_d    = S_FETCH;
            end

            S_HALT: halted = 1'b1;

            default: state_d = S_IDLE;
        endcase

        // Nothing may strobe while reset is held, whatever state is being abandoned.
        if (!rst_n) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_load    = 1'b0;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            r15_write  = 1'b0;
            branch     = 1'b0;
            halted     = 1'b0;
            bus_err    = 1'b0;
            illegal    = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;
    logic             retire;

    // Illegal opcodes leave DECODE for FETCH too but do not count as retired.
    assign retire = (state_d == S_FETCH) && !illegal &&
                    ((state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM) || (state_q == S_WB));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (retire) begin
                ret_q <= ret_q + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt = rst_n ? cyc_q : '0;
    assign ret_cnt = rst_n ? ret_q : '0;
`endif

endmodule
